// File: rtl/bsg_cache_dma_rr_arbiter.sv
// bsg_cache_dma_rr_arbiter
// Shares one downstream DMA port between num_cache_p bsg_cache DMA ports.
// Each grant goes to one cache. That cache's packet is routed downstream,
// then exactly one block of fill data (read) or evict data (write) is routed,
// and then the grant is released.
// Ports:
//   clk_i, reset_n_i                    clock, synchronous active-low reset
//   dma_pkt_i/_v_i/_yumi_o              per-cache packet {write_not_read, addr}
//   dma_data_o/_v_o, dma_data_ready_i   per-cache fill data (memory -> cache)
//   dma_data_i/_v_i, dma_data_yumi_o    per-cache evict data (cache -> memory)
//   mem_pkt_o/_v_o, mem_pkt_yumi_i      downstream packet
//   mem_data_i/_v_i, mem_data_ready_o   downstream fill data
//   mem_data_o/_v_o, mem_data_yumi_i    downstream evict data
//   grant_id_o, busy_o                  current grant, arbiter not idle
module bsg_cache_dma_rr_arbiter #(
    parameter int unsigned num_cache_p           = 4,
    parameter int unsigned addr_width_p          = 32,
    parameter int unsigned data_width_p          = 32,
    parameter int unsigned block_size_in_words_p = 4,
    localparam int unsigned pkt_width_lp         = addr_width_p + 1,
    localparam int unsigned lg_cache_lp          = (num_cache_p > 1) ? $clog2(num_cache_p) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,

    input  logic [num_cache_p-1:0][pkt_width_lp-1:0] dma_pkt_i,
    input  logic [num_cache_p-1:0]                   dma_pkt_v_i,
    output logic [num_cache_p-1:0]                   dma_pkt_yumi_o,

    output logic [num_cache_p-1:0][data_width_p-1:0] dma_data_o,
    output logic [num_cache_p-1:0]                   dma_data_v_o,
    input  logic [num_cache_p-1:0]                   dma_data_ready_i,

    input  logic [num_cache_p-1:0][data_width_p-1:0] dma_data_i,
    input  logic [num_cache_p-1:0]                   dma_data_v_i,
    output logic [num_cache_p-1:0]                   dma_data_yumi_o,

    output logic [pkt_width_lp-1:0]                  mem_pkt_o,
    output logic                                     mem_pkt_v_o,
    input  logic                                     mem_pkt_yumi_i,

    input  logic [data_width_p-1:0]                  mem_data_i,
    input  logic                                     mem_data_v_i,
    output logic                                     mem_data_ready_o,

    output logic [data_width_p-1:0]                  mem_data_o,
    output logic                                     mem_data_v_o,
    input  logic                                     mem_data_yumi_i,

    output logic [lg_cache_lp-1:0]                   grant_id_o,
    output logic                                     busy_o
);

    localparam int unsigned cnt_width_lp =
        (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
    localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(block_size_in_words_p - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2,
        WDATA = 2'd3
    } state_e;

    state_e                  state_r;
    logic [lg_cache_lp-1:0]  grant_r;
    logic [lg_cache_lp-1:0]  last_r;
    logic [cnt_width_lp-1:0] cnt_r;

    logic                    pick_v;
    logic [lg_cache_lp-1:0]  pick_id;

    // Round-robin pick: first valid requester after last_r, wrapping.
    // Scanning farthest-to-nearest lets the nearest valid index win.
    always_comb begin
        int unsigned idx;
        logic [lg_cache_lp-1:0] id;
        pick_v  = 1'b0;
        pick_id = '0;
        idx     = 0;
        id      = '0;
        for (int unsigned k = num_cache_p; k >= 1; k--) begin
            idx = (32'(last_r) + k) % num_cache_p;
            id  = lg_cache_lp'(idx);
            if (dma_pkt_v_i[id]) begin
                pick_v  = 1'b1;
                pick_id = id;
            end
        end
    end

    // State, grant and beat counter.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            grant_r <= '0;
            last_r  <= lg_cache_lp'(num_cache_p - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_v) begin
                        grant_r <= pick_id;
                        last_r  <= pick_id;
                        state_r <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_pkt_yumi_i) begin
                        cnt_r   <= '0;
                        state_r <= dma_pkt_i[grant_r][addr_width_p] ? WDATA : RDATA;
                    end
                end
                RDATA: begin
                    if (mem_data_v_i && dma_data_ready_i[grant_r]) begin
                        cnt_r <= cnt_r + cnt_width_lp'(1);
                        if (cnt_r == cnt_last_lp) state_r <= IDLE;
                    end
                end
                WDATA: begin
                    if (mem_data_yumi_i) begin
                        cnt_r <= cnt_r + cnt_width_lp'(1);
                        if (cnt_r == cnt_last_lp) state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Handshake routing to/from the granted cache; all strobes held low in reset.
    always_comb begin
        dma_pkt_yumi_o   = '0;
        dma_data_v_o     = '0;
        dma_data_yumi_o  = '0;
        mem_pkt_o        = dma_pkt_i[grant_r];
        mem_pkt_v_o      = 1'b0;
        mem_data_ready_o = 1'b0;
        mem_data_o       = dma_data_i[grant_r];
        mem_data_v_o     = 1'b0;
        if (reset_n_i) begin
            case (state_r)
                ISSUE: begin
                    mem_pkt_v_o             = 1'b1;
                    dma_pkt_yumi_o[grant_r] = mem_pkt_yumi_i;
                end
                RDATA: begin
                    dma_data_v_o[grant_r] = mem_data_v_i;
                    mem_data_ready_o      = dma_data_ready_i[grant_r];
                end
                WDATA: begin
                    mem_data_v_o             = dma_data_v_i[grant_r];
                    dma_data_yumi_o[grant_r] = mem_data_yumi_i;
                end
                default: ;
            endcase
        end
    end

    // Fill data is broadcast; only the granted cache sees valid.
    assign dma_data_o = {num_cache_p{mem_data_i}};

    assign busy_o     = reset_n_i && (state_r != IDLE);
    assign grant_id_o = reset_n_i ? grant_r : '0;

endmodule
